// File: rtl/overlay_pkg.sv
// Shared types and glyph geometry for the GAME OVER overlay controller.
package overlay_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REVEAL = 2'd1,
        BLINK  = 2'd2,
        SHOW   = 2'd3
    } state_t;

    localparam int GLYPH_W   = 256;
    localparam int GLYPH_H   = 32;
    localparam int SLOT_W    = 32;
    localparam int NUM_SLOTS = 8;

endpackage

// File: rtl/overlay_frame_timer.sv
// Frame divider: pulses tick on every N-th counted frame_start; clr holds the count at zero.
module overlay_frame_timer #(
    parameter int unsigned N = 8
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic frame_start,
    output logic tick
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt;

    assign tick = frame_start & ~clr & (cnt == CW'(N - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (frame_start) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/game_over_overlay_ctrl.sv
// GAME OVER banner sequencer: raster-to-ROM addressing, 2-stage pixel pipe, reveal/blink/show animation.
// Build option: define OVERLAY_BLINK_EN to insert the BLINK phase between REVEAL and SHOW.
module game_over_overlay_ctrl
    import overlay_pkg::*;
#(
    parameter int unsigned ORIGIN_X      = 192,
    parameter int unsigned ORIGIN_Y      = 224,
    parameter int unsigned SCALE_SHIFT   = 0,
    parameter int unsigned REVEAL_FRAMES = 8,
    parameter int unsigned BLINK_FRAMES  = 16,
    parameter int unsigned BLINK_COUNT   = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       game_over,
    input  logic       restart,
    input  logic       rom_bit,
    output logic [7:0] letter_x,
    output logic [7:0] letter_y,
    output logic       overlay_pix,
    output logic       overlay_busy,
    output logic       reveal_done
);

    state_t     state, next_state;
    logic [3:0] reveal_cnt;
    logic       reveal_tick;
    logic       visible;
    logic       slots_open;

    overlay_frame_timer #(.N(REVEAL_FRAMES)) u_reveal_timer (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .clr         (next_state != REVEAL),
        .frame_start (frame_start),
        .tick        (reveal_tick)
    );

`ifdef OVERLAY_BLINK_EN
    localparam int TW = $clog2(2 * BLINK_COUNT);

    logic [TW-1:0] toggle_cnt;
    logic          blink_tick;
    logic          blink_done;
    logic          enter_blink;

    // Entry is decoded from registered state so the timer clear does not loop through next_state.
    assign enter_blink = (state == REVEAL) && (reveal_cnt == 4'(NUM_SLOTS)) && !restart;
    assign blink_done  = blink_tick && (toggle_cnt == TW'(2 * BLINK_COUNT - 1));

    overlay_frame_timer #(.N(BLINK_FRAMES)) u_blink_timer (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .clr         (!((state == BLINK) || enter_blink)),
        .frame_start (frame_start),
        .tick        (blink_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            toggle_cnt <= '0;
        end else if (state != BLINK) begin
            toggle_cnt <= '0;
        end else if (blink_tick) begin
            toggle_cnt <= toggle_cnt + TW'(1);
        end
    end

    // Blink opens in the off phase; the final toggle lands in SHOW with the banner on.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            visible <= 1'b0;
        end else if (next_state != BLINK) begin
            visible <= 1'b1;
        end else if (state != BLINK) begin
            visible <= 1'b0;
        end else if (blink_tick) begin
            visible <= ~visible;
        end
    end
`else
    assign visible = 1'b1;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        if (restart) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:   if (game_over) next_state = REVEAL;
`ifdef OVERLAY_BLINK_EN
                REVEAL: if (reveal_cnt == 4'(NUM_SLOTS)) next_state = BLINK;
                BLINK:  if (blink_done) next_state = SHOW;
`else
                REVEAL: if (reveal_cnt == 4'(NUM_SLOTS)) next_state = SHOW;
`endif
                SHOW:   next_state = SHOW;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        overlay_busy = (state != IDLE);
        reveal_done  = (reveal_cnt == 4'(NUM_SLOTS));
        slots_open   = (state == BLINK) || (state == SHOW);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            reveal_cnt <= '0;
        end else if (next_state == IDLE) begin
            reveal_cnt <= '0;
        end else if (reveal_tick && (reveal_cnt != 4'(NUM_SLOTS))) begin
            reveal_cnt <= reveal_cnt + 4'd1;
        end
    end

    // Stage 1: 11-bit subtraction makes left/above-origin pixels wrap huge and fail the box test.
    logic [10:0] rel_x, rel_y;
    logic        in_box;
    logic [7:0]  lx_d, ly_d;
    logic        s1_en_d, s1_en;

    always_comb begin
        rel_x   = {1'b0, pix_x} - 11'(ORIGIN_X);
        rel_y   = {1'b0, pix_y} - 11'(ORIGIN_Y);
        in_box  = pix_valid
                && (rel_x < 11'(GLYPH_W << SCALE_SHIFT))
                && (rel_y < 11'(GLYPH_H << SCALE_SHIFT));
        lx_d    = in_box ? 8'(rel_x >> SCALE_SHIFT) : 8'd0;
        ly_d    = in_box ? 8'(rel_y >> SCALE_SHIFT) : 8'd0;
        s1_en_d = in_box && (slots_open || ({1'b0, lx_d[7:5]} < reveal_cnt)) && visible;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            letter_x    <= '0;
            letter_y    <= '0;
            s1_en       <= 1'b0;
            overlay_pix <= 1'b0;
        end else begin
            letter_x    <= lx_d;
            letter_y    <= ly_d;
            s1_en       <= s1_en_d;
            overlay_pix <= s1_en & rom_bit;
        end
    end

endmodule
